// File: rtl/cnn_pkg.sv
// Shared geometry for the CNN window generator and the conv stage, so that the
// window element ordering and the weight ordering are derived from the same constants.
package cnn_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned INPUT_SIZE  = 34;
  localparam int unsigned FILTER_SIZE = 7;
  localparam int unsigned CNN_STRIDE  = 2;

  // Number of window positions along one image dimension.
  function automatic int unsigned calc_out_size(int unsigned in_size, int unsigned filt,
                                                int unsigned stride);
    return (in_size - filt) / stride + 1;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int unsigned calc_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned OUT_SIZE    = calc_out_size(INPUT_SIZE, FILTER_SIZE, CNN_STRIDE);
  localparam int unsigned COORD_WIDTH = calc_width(OUT_SIZE);
  localparam int unsigned PIX_WIDTH   = calc_width(INPUT_SIZE);

  typedef logic [DATA_WIDTH-1:0] pixel_t;

endpackage

// File: rtl/cnn_line_buffer.sv
// Column-addressed store of the last Depth image rows; one read returns a whole column,
// one write shifts that column up and inserts the newest pixel at the bottom.
module cnn_line_buffer #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 6,
  parameter int unsigned Width     = 34,
  parameter int unsigned AddrWidth = 6
) (
  input  logic                       clk_i,
  input  logic [AddrWidth-1:0]       col_i,
  output logic [Depth*DataWidth-1:0] rd_data_o,
  input  logic                       wr_en_i,
  input  logic [DataWidth-1:0]       wr_data_i
);

  logic [DataWidth-1:0] mem_q [Width][Depth];

  // Entry 0 is the oldest row of the column.
  always_comb begin
    rd_data_o = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      rd_data_o[i*DataWidth +: DataWidth] = mem_q[col_i][i];
    end
  end

  // Contents need no reset: a new frame rewrites every entry before its first window.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int unsigned i = 0; i + 1 < Depth; i++) begin
        mem_q[col_i][i] <= mem_q[col_i][i+1];
      end
      mem_q[col_i][Depth-1] <= wr_data_i;
    end
  end

endmodule

// File: rtl/cnn_window_gen.sv
// Raster pixel stream in, flattened FxF windows at stride S out, with grid coordinates
// and a last-of-frame flag. One pixel per cycle when the consumer keeps up.
module cnn_window_gen
  import cnn_pkg::*;
#(
  parameter int unsigned input_size  = INPUT_SIZE,
  parameter int unsigned filter_size = FILTER_SIZE,
  parameter int unsigned cnn_stride  = CNN_STRIDE,
  parameter int unsigned data_width  = DATA_WIDTH,
  localparam int unsigned CoordWidth =
    calc_width(calc_out_size(input_size, filter_size, cnn_stride))
) (
  input  logic                                       clk,
  input  logic                                       rstb,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [data_width-1:0]                      in_data,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [filter_size*filter_size*data_width-1:0] out_window,
  output logic [CoordWidth-1:0]                      out_row,
  output logic [CoordWidth-1:0]                      out_col,
  output logic                                       out_last
);

  localparam int unsigned F        = filter_size;
  localparam int unsigned OutSize  = calc_out_size(input_size, filter_size, cnn_stride);
  localparam int unsigned PixWidth = calc_width(input_size);
  localparam int unsigned WinWidth = F * F * data_width;

  logic [PixWidth-1:0]   row_q, row_d;
  logic [PixWidth-1:0]   col_q, col_d;
  logic [data_width-1:0] win_q [F][F];
  logic [data_width-1:0] win_d [F][F];
  logic [(F-1)*data_width-1:0] lb_col;
  logic [WinWidth-1:0]   win_flat;

  logic                  accept;
  logic                  row_hit, col_hit, load;
  logic [CoordWidth-1:0] grid_row, grid_col;

  logic                  out_valid_q, out_valid_d;
  logic [WinWidth-1:0]   out_window_q, out_window_d;
  logic [CoordWidth-1:0] out_row_q, out_row_d;
  logic [CoordWidth-1:0] out_col_q, out_col_d;
  logic                  out_last_q, out_last_d;

  // Accept only when any held window is being drained this cycle.
  assign in_ready = !rstb && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  cnn_line_buffer #(
    .DataWidth (data_width),
    .Depth     (F - 1),
    .Width     (input_size),
    .AddrWidth (PixWidth)
  ) u_line_buffer (
    .clk_i     (clk),
    .col_i     (col_q),
    .rd_data_o (lb_col),
    .wr_en_i   (accept),
    .wr_data_i (in_data)
  );

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (accept) begin
      if (col_q == PixWidth'(input_size - 1)) begin
        col_d = '0;
        row_d = (row_q == PixWidth'(input_size - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Stride phase and grid coordinates of the pixel being accepted.
  always_comb begin
    row_hit  = 1'b0;
    col_hit  = 1'b0;
    grid_row = '0;
    grid_col = '0;
    if (32'(row_q) >= F - 1) begin
      row_hit  = ((32'(row_q) - (F - 1)) % cnn_stride) == 32'd0;
      grid_row = CoordWidth'((32'(row_q) - (F - 1)) / cnn_stride);
    end
    if (32'(col_q) >= F - 1) begin
      col_hit  = ((32'(col_q) - (F - 1)) % cnn_stride) == 32'd0;
      grid_col = CoordWidth'((32'(col_q) - (F - 1)) / cnn_stride);
    end
  end

  assign load = accept && row_hit && col_hit;

  // Window slides left; the new right column is the buffered column plus the new pixel.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int unsigned r = 0; r < F; r++) begin
        for (int unsigned c = 0; c + 1 < F; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      for (int unsigned r = 0; r + 1 < F; r++) begin
        win_d[r][F-1] = lb_col[r*data_width +: data_width];
      end
      win_d[F-1][F-1] = in_data;
    end
  end

  always_comb begin
    win_flat = '0;
    for (int unsigned r = 0; r < F; r++) begin
      for (int unsigned c = 0; c < F; c++) begin
        win_flat[(r*F+c)*data_width +: data_width] = win_d[r][c];
      end
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_window_d = out_window_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    out_last_d   = out_last_q;
    if (load) begin
      out_valid_d  = 1'b1;
      out_window_d = win_flat;
      out_row_d    = grid_row;
      out_col_d    = grid_col;
      out_last_d   = (grid_row == CoordWidth'(OutSize - 1)) &&
                     (grid_col == CoordWidth'(OutSize - 1));
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      row_q        <= '0;
      col_q        <= '0;
      out_valid_q  <= 1'b0;
      out_window_q <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      out_last_q   <= 1'b0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      out_valid_q  <= out_valid_d;
      out_window_q <= out_window_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      out_last_q   <= out_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      win_q <= win_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_window = out_window_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign out_last   = out_last_q;

endmodule

// File: tb/tb_cnn_window_gen.sv
// Randomized bench for cnn_window_gen: frames are described as whole images and the
// expected window list is cut straight out of them.
module tb_cnn_window_gen;
  import cnn_pkg::*;

  localparam int unsigned N     = INPUT_SIZE;
  localparam int unsigned F     = FILTER_SIZE;
  localparam int unsigned S     = CNN_STRIDE;
  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned OS    = OUT_SIZE;
  localparam int unsigned CW    = COORD_WIDTH;
  localparam int unsigned WW    = F * F * DW;
  localparam int unsigned FRAME = N * N;

  logic          clk = 1'b0;
  logic          rstb;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_window;
  logic [CW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          out_last;

  always #5 clk = ~clk;

  cnn_window_gen dut (
    .clk        (clk),
    .rstb       (rstb),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_window (out_window),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_last   (out_last)
  );

  typedef struct {
    logic [WW-1:0] win;
    int unsigned   row;
    int unsigned   col;
    bit            last;
    int unsigned   br;  // global index of the bottom-right pixel
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] pix_q[$];
  int unsigned   checks = 0;
  int unsigned   errors = 0;
  int unsigned   acc_cnt = 0;
  int unsigned   frame_cnt = 0;
  int unsigned   win_seen = 0;
  int unsigned   last_seen = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // mode 0: ramp, 1: ramp + 10000, 2: random words
  task automatic push_frame(input int unsigned mode);
    logic [DW-1:0] img [FRAME];
    exp_t e;
    for (int unsigned idx = 0; idx < FRAME; idx++) begin
      case (mode)
        0:       img[idx] = DW'(idx);
        1:       img[idx] = DW'(10000 + idx);
        default: img[idx] = $urandom;
      endcase
      pix_q.push_back(img[idx]);
    end
    for (int unsigned i = 0; i < OS; i++) begin
      for (int unsigned j = 0; j < OS; j++) begin
        e.win = '0;
        for (int unsigned r = 0; r < F; r++) begin
          for (int unsigned c = 0; c < F; c++) begin
            e.win[(r*F+c)*DW +: DW] = img[(S*i+r)*N + S*j + c];
          end
        end
        e.row  = i;
        e.col  = j;
        e.last = (i == OS - 1) && (j == OS - 1);
        e.br   = frame_cnt * FRAME + (S*i + F - 1) * N + S*j + F - 1;
        exp_q.push_back(e);
      end
    end
    frame_cnt++;
  endtask

  task automatic run(input int unsigned vprob, input int unsigned rprob,
                     input int unsigned stop_acc, input int unsigned hold,
                     input int unsigned budget, output int unsigned cycles);
    exp_t        e;
    int unsigned k;
    int unsigned hold_left = hold;
    cycles = 0;
    while (cycles < budget) begin
      if (pix_q.size() == 0 && exp_q.size() == 0) break;
      if (stop_acc != 0 && acc_cnt >= stop_acc) break;
      @(negedge clk);
      in_valid  = (pix_q.size() > 0) && ($urandom_range(99) < vprob);
      in_data   = (pix_q.size() > 0) ? pix_q[0] : '0;
      out_ready = $urandom_range(99) < rprob;
      if (hold_left > 0 && out_valid) begin
        out_ready = 1'b0;
        hold_left--;
      end
      #1;
      check("in_ready", in_ready, !out_valid || out_ready);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_window", 1, 0);
        end else begin
          e = exp_q[0];
          k = 0;
          for (int unsigned w = 0; w < F * F; w++) begin
            if (out_window[w*DW +: DW] !== e.win[w*DW +: DW]) begin
              k = w;
              break;
            end
          end
          check($sformatf("win(%0d,%0d)w%0d", e.row, e.col, k),
                out_window[k*DW +: DW], e.win[k*DW +: DW]);
          check("out_row", out_row, e.row);
          check("out_col", out_col, e.col);
          check("out_last", out_last, e.last);
          check("pixels_at_window", acc_cnt, e.br + 1);
          if (out_ready) begin
            void'(exp_q.pop_front());
            win_seen++;
            if (out_last) last_seen++;
          end
        end
      end
      if (in_valid && in_ready) begin
        void'(pix_q.pop_front());
        acc_cnt++;
      end
      cycles++;
    end
    if (cycles >= budget) check("timeout", 1, 0);
  endtask

  task automatic reset_pulse(input int unsigned n);
    @(negedge clk);
    rstb      = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = '0;
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
    end
    check("rst_out_row", out_row, 0);
    check("rst_out_col", out_col, 0);
    check("rst_out_last", out_last, 0);
    check("rst_window_nonzero", |out_window, 0);
    @(negedge clk);
    rstb     = 1'b0;
    in_valid = 1'b0;
    pix_q.delete();
    exp_q.delete();
    acc_cnt   = 0;
    frame_cnt = 0;
  endtask

  int unsigned cyc, w0, l0;

  initial begin
    rstb      = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    reset_pulse(3);

    // Ramp frame, full throughput.
    w0 = win_seen; l0 = last_seen;
    push_frame(0);
    run(100, 100, 0, 0, 5000, cyc);
    check("ramp_cycles", cyc, FRAME);
    check("ramp_windows", win_seen - w0, OS * OS);
    check("ramp_last", last_seen - l0, 1);

    // First window held for 20 cycles.
    w0 = win_seen;
    push_frame(0);
    run(100, 100, 0, 20, 5000, cyc);
    check("hold_windows", win_seen - w0, OS * OS);

    // Two back-to-back frames.
    w0 = win_seen; l0 = last_seen;
    push_frame(0);
    push_frame(1);
    run(100, 100, 0, 0, 10000, cyc);
    check("two_frame_windows", win_seen - w0, 2 * OS * OS);
    check("two_frame_last", last_seen - l0, 2);

    // Reset in the middle of a frame, then a clean ramp.
    push_frame(0);
    run(100, 100, acc_cnt + 500, 0, 5000, cyc);
    reset_pulse(1);
    w0 = win_seen; l0 = last_seen;
    push_frame(0);
    run(100, 100, 0, 0, 5000, cyc);
    check("post_reset_cycles", cyc, FRAME);
    check("post_reset_windows", win_seen - w0, OS * OS);
    check("post_reset_last", last_seen - l0, 1);

    // Random input gaps and consumer stalls.
    w0 = win_seen; l0 = last_seen;
    push_frame(0);
    run(70, 60, 0, 0, 20000, cyc);
    push_frame(2);
    push_frame(2);
    run(60, 45, 0, 0, 40000, cyc);
    check("random_windows", win_seen - w0, 3 * OS * OS);
    check("random_last", last_seen - l0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
